uart_frame_sched: RTL

Two-requester scheduler that shares one byte-wide UART transmitter between two 64-bit frame sources. Each requester presents a 64-bit word and holds a request. The block grants requesters round-robin and latches the granted word. It then feeds the word to the transmitter one byte at a time, MSB byte first, using the transmitter's start/done handshake. It sits between the frame producers (manual-start capture, status reporter) and `uart_tx`, replacing the direct byte-sequencing logic in `top_in`.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_frame_sched_arb.sv | 20 ++
 rtl/uart_frame_sched.sv | 135 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants for the UART frame scheduler.
// FSM state encoding and frame/bit-time parameters.
package uart_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_SEND = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_ACK  = 3'd4;

  localparam int UART_BIT_NS = 8681;
  localparam int FRAME_BYTES = 8;

endpackage

// File: rtl/uart_frame_sched_arb.sv
// rr_arb2: two-input round-robin arbiter.
// Grants the requester not served last on contention.
module rr_arb2
  import uart_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       en,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (&req) gnt = last ? 2'b01 : 2'b10;
      else      gnt = req;
    end
  end

endmodule

// File: rtl/uart_frame_sched.sv
// uart_frame_sched: shares one byte UART between two frame sources.
// Optional trailing XOR checksum byte: UART_FRAME_CHECKSUM_EN.
module uart_frame_sched
  import uart_pkg::*;
#(
  parameter int NBYTES = FRAME_BYTES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_a,
  input  logic [8*NBYTES-1:0] data_a,
  output logic                ack_a,
  input  logic                req_b,
  input  logic [8*NBYTES-1:0] data_b,
  output logic                ack_b,
  output logic                tx_start,
  output logic [7:0]          tx_data,
  input  logic                tx_busy,
  input  logic                tx_done,
  output logic                busy,
  output logic                owner
);

  localparam int W = 8 * NBYTES;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam logic [3:0] LAST_IDX = 4'(NBYTES);
`else
  localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);
`endif

  logic [2:0]   state_q, state_d;
  logic [W-1:0] shreg_q, shreg_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         owner_q, owner_d;
  logic         last_q, last_d;
  logic [7:0]   txd_q, txd_d;
  logic [1:0]   gnt;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]   csum_q, csum_d;
`endif

  rr_arb2 u_arb (
    .req  ({req_b, req_a}),
    .last (last_q),
    .en   (state_q == ST_IDLE),
    .gnt  (gnt)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    txd_d   = txd_q;
`ifdef UART_FRAME_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          owner_d = gnt[1];
          shreg_d = gnt[1] ? data_b : data_a;
          cnt_d   = '0;
`ifdef UART_FRAME_CHECKSUM_EN
          csum_d  = '0;
`endif
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
`ifdef UART_FRAME_CHECKSUM_EN
        // index NBYTES is the trailing checksum slot
        if (cnt_q == 4'(NBYTES)) begin
          txd_d = csum_q;
        end else begin
          txd_d  = shreg_q[W-1 -: 8];
          csum_d = csum_q ^ shreg_q[W-1 -: 8];
        end
`else
        txd_d = shreg_q[W-1 -: 8];
`endif
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (!tx_busy) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done) begin
          shreg_d = shreg_q << 8;
          cnt_d   = cnt_q + 4'd1;
          state_d = (cnt_q == LAST_IDX) ? ST_ACK : ST_LOAD;
        end
      end
      ST_ACK: begin
        last_d  = owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      txd_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      txd_q   <= txd_d;
    end
  end

`ifdef UART_FRAME_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csum_q <= '0;
    else        csum_q <= csum_d;
  end
`endif

  assign tx_start = (state_q == ST_SEND) && !tx_busy;
  assign tx_data  = txd_q;
  assign ack_a    = (state_q == ST_ACK) && !owner_q;
  assign ack_b    = (state_q == ST_ACK) && owner_q;
  assign busy     = (state_q != ST_IDLE);
  assign owner    = owner_q;

endmodule
